// File: rtl/fib_stream_reader.sv
// Walks a Fibonacci ROM address range and streams the words out over valid/ready.
// Optional recurrence checker is compiled in with `FIB_STREAM_CHECK_EN.
module fib_stream_reader #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adr,
  input  logic [5:0]        count,
  output logic              busy,
  output logic              bad_req,
  output logic [ADDR_W-1:0] rom_adr,
  input  logic [DATA_W-1:0] rom_dat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              chk_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   rom_adr_q;
  logic [5:0]          remaining_q;
  logic [5:0]          remaining_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                done_q;
  logic                bad_req_q;
  logic [ADDR_W-1:0]   avail;
  logic                req_bad;
  logic                free;

  assign avail       = ADDR_W'(DEPTH) - start_adr;
  assign req_bad     = (count == 6'd0) || (start_adr >= ADDR_W'(DEPTH));
  // avail is at most DEPTH here, so the narrowing only matters when it wins the min
  assign remaining_d = (ADDR_W'(count) < avail) ? count : avail[5:0];
  assign free        = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_adr_q   <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      bad_req_q   <= 1'b0;
    end else begin
      bad_req_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (req_bad) begin
              bad_req_q <= 1'b1;
            end else begin
              rom_adr_q   <= start_adr;
              remaining_q <= remaining_d;
              state_q     <= RUN;
            end
          end
        end
        RUN: begin
          if (free) begin
            out_data_q  <= rom_dat;
            out_valid_q <= 1'b1;
            rom_adr_q   <= rom_adr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == 6'd1) begin
              out_last_q <= 1'b1;
              state_q    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign bad_req   = bad_req_q;
  assign rom_adr   = rom_adr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

`ifdef FIB_STREAM_CHECK_EN
  logic [DATA_W-1:0] prev1_q;
  logic [DATA_W-1:0] prev2_q;
  logic [1:0]        hist_q;
  logic              chk_err_q;
  logic              accept;
  logic              start_ok;

  assign accept   = out_valid_q && out_ready;
  assign start_ok = (state_q == IDLE) && start && !req_bad;

  // hist_q saturates at 2: once two words are held every accepted word is checked
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      prev1_q   <= '0;
      prev2_q   <= '0;
      hist_q    <= '0;
      chk_err_q <= 1'b0;
    end else if (accept) begin
      if (hist_q == 2'd2 && out_data_q != DATA_W'(prev1_q + prev2_q)) begin
        chk_err_q <= 1'b1;
      end
      prev2_q <= prev1_q;
      prev1_q <= out_data_q;
      if (hist_q != 2'd2) begin
        hist_q <= hist_q + 2'd1;
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_stream_reader.sv
// Directed bench for fib_stream_reader: bursts, backpressure, clamp, rejects, reset, checker.
module tb_fib_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] start_adr;
  logic [5:0]  count;
  logic        busy;
  logic        bad_req;
  logic [23:0] rom_adr;
  logic [23:0] rom_dat;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_last;
  logic        done;
  logic        chk_err;
  logic        force_en;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_q[$];

  fib_stream_reader #(.ADDR_W(24), .DATA_W(24), .DEPTH(36)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_adr (start_adr),
    .count     (count),
    .busy      (busy),
    .bad_req   (bad_req),
    .rom_adr   (rom_adr),
    .rom_dat   (rom_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] fib(input logic [23:0] a);
    logic [23:0] x, y, t;
    x = 24'd0;
    y = 24'd1;
    if (a >= 24'd36) return 24'd0;
    for (int unsigned i = 0; i < a; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always_comb rom_dat = (force_en && rom_adr == 24'd6) ? 24'd100 : fib(rom_adr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rpat 0: out_ready always high; rpat 1: out_ready 1,0,0 repeating
  task automatic run_burst(input logic [23:0] adr, input logic [5:0] cnt, input int unsigned rpat);
    int unsigned idx, cyc;
    logic done_seen, stalled;
    logic [23:0] held;
    idx = 0; cyc = 0; done_seen = 1'b0; stalled = 1'b0; held = '0;
    start = 1'b1; start_adr = adr; count = cnt;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("rom_adr_after_start", rom_adr, adr);
    check("no_bad_req", bad_req, 0);
    check("chk_err_clear_on_start", chk_err, 0);
    while (!done_seen && cyc < 200) begin
      out_ready = (rpat == 0) ? 1'b1 : (cyc % 3 == 0);
      if (stalled) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_stable", out_data, held);
      end
      if (rpat == 0 && cyc == 1) check("first_word_latency", out_valid, 1);
      if (out_valid && out_ready) begin
        if (idx < exp_q.size()) check("word", out_data, exp_q[idx]);
        else check("extra_word", idx, exp_q.size());
        check("last_flag", out_last, (idx == exp_q.size() - 1));
        idx++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      tick();
      cyc++;
      if (done) begin
        done_seen = 1'b1;
        check("words_before_done", idx, exp_q.size());
        check("busy_falls_with_done", busy, 0);
        check("valid_drops_at_done", out_valid, 0);
        if (rpat == 0) check("done_cycle", cyc, exp_q.size() + 1);
      end
    end
    check("done_seen", done_seen, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic done_any;
    rst_n = 1'b0; start = 1'b0; start_adr = '0; count = '0;
    out_ready = 1'b0; force_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rom_adr", rom_adr, 0);
    check("rst_done", done, 0);
    check("rst_chk_err", chk_err, 0);

    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13};
    run_burst(24'd0, 6'd8, 0);
    check("basic_chk_err", chk_err, 0);
    tick();
    check("done_one_cycle", done, 0);

    exp_q = '{55, 89, 144, 233};
    run_burst(24'd10, 6'd4, 1);

    exp_q = '{3524578, 5702887, 9227465};
    run_burst(24'd33, 6'd10, 0);

    start = 1'b1; start_adr = 24'd36; count = 6'd1;
    tick();
    start = 1'b0;
    check("rej_adr_bad_req", bad_req, 1);
    check("rej_adr_busy", busy, 0);
    check("rej_adr_valid", out_valid, 0);
    tick();
    check("rej_adr_pulse_ends", bad_req, 0);
    start = 1'b1; start_adr = 24'd0; count = 6'd0;
    tick();
    start = 1'b0;
    check("rej_cnt_bad_req", bad_req, 1);
    check("rej_cnt_busy", busy, 0);
    tick();
    check("rej_cnt_valid", out_valid, 0);
    check("rej_cnt_pulse_ends", bad_req, 0);

    out_ready = 1'b1;
    start = 1'b1; start_adr = 24'd0; count = 6'd20;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid_rom_adr", rom_adr, 3);
    start = 1'b1; start_adr = 24'd30; count = 6'd1;
    tick();
    start = 1'b0;
    check("busy_start_ignored_adr", rom_adr, 4);
    check("busy_start_no_bad_req", bad_req, 0);
    check("busy_start_data", out_data, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", out_data, 0);
    check("abort_last", out_last, 0);
    check("abort_rom_adr", rom_adr, 0);
    check("abort_chk_err", chk_err, 0);
    done_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      done_any = done_any | done | out_valid;
    end
    check("abort_quiet", done_any, 0);
    out_ready = 1'b0;
    exp_q = '{5, 8};
    run_burst(24'd5, 6'd2, 0);

    force_en = 1'b1;
    exp_q = '{3, 5, 100, 13};
    run_burst(24'd4, 6'd4, 0);
    force_en = 1'b0;
`ifdef FIB_STREAM_CHECK_EN
    check("chk_err_set", chk_err, 1);
    tick(); tick(); tick();
    check("chk_err_sticky", chk_err, 1);
`else
    check("chk_err_tied", chk_err, 0);
    tick();
`endif
    exp_q = '{0, 1, 1};
    run_burst(24'd0, 6'd3, 0);
    check("chk_err_after_clean", chk_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
